// File: rtl/ram_rd_streamer.sv
// Streams LEN consecutive RAM words (wrapping at RAM_DEPTH) out on a valid/ready port.
// A credit-limited read pipe and a small FWFT FIFO cover the RAM's registered read latency.
module ram_rd_streamer #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        ram_addr_rd,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready
);
  // Stream handshake: a word transfers on any cycle with m_valid && m_ready;
  // m_valid never drops and m_data never changes until that transfer happens.

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [AW:0]            r_issue_left, r_rcv_left;
  logic [AW-1:0]          r_addr;
  logic [RD_LATENCY-1:0]  r_pipe;
  logic [RAM_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic [CW-1:0]          w_inflight;
  logic [CW:0]            w_occ;
  logic                   w_issue, w_push, w_pop, w_last_hs;
  logic [AW-1:0]          w_addr_nxt;
  logic [PW-1:0]          w_wr_nxt, w_rd_nxt;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + CW'(r_pipe[i]);
  end

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign w_occ      = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_issue    = (r_state == S_RUN) && (r_issue_left != '0) && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_push     = r_pipe[RD_LATENCY-1];
  assign m_valid    = (r_count != '0);
  assign m_data     = r_fifo[r_rd_ptr];
  assign m_last     = m_valid && (r_rcv_left == (AW+1)'(1));
  assign w_pop      = m_valid && m_ready;
  assign w_last_hs  = w_pop && (r_rcv_left == (AW+1)'(1));
  assign w_addr_nxt = (r_addr == AW'(RAM_DEPTH-1)) ? '0 : r_addr + 1'b1;
  assign w_wr_nxt   = (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt   = (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
  assign ram_addr_rd = r_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = (length == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last_hs) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_issue_left <= '0;
      r_rcv_left   <= '0;
      r_pipe       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr       <= base_addr;
        r_issue_left <= length;
        r_rcv_left   <= length;
      end else begin
        if (w_issue) begin
          r_addr       <= w_addr_nxt;
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_pop) r_rcv_left <= r_rcv_left - 1'b1;
      end
      r_pipe <= (r_pipe << 1) | RD_LATENCY'(w_issue);
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ram_data_out;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) assert (r_count != CW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer: a 2-cycle registered RAM model, a word-list reference
// built from base/length, and a per-cycle sampler scoring the stream and read credits.
module tb_ram_rd_streamer;
  localparam int W = 8;
  localparam int D = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, m_valid, m_last, m_ready;
  logic [AW-1:0] base_addr, ram_addr_rd, ram_addr_q;
  logic [AW:0]   length;
  logic [W-1:0]  ram_data_out, m_data;
  logic [W-1:0]  mem [D];

  logic [W-1:0]  exp_q[$];
  int            n_vec = 0, n_err = 0;
  int            cyc = 0, rdy_mode = 0;
  int            issues = 0, pops = 0, iss0 = 0, pops0 = 0;
  int            start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  logic          prev_busy = 1'b0, seen_valid, done_flag, busy_at_done;
  logic [AW-1:0] prev_addr = '0;

  ram_rd_streamer #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr_rd(ram_addr_rd), .ram_data_out(ram_data_out),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // RAM with registered address and registered data: two cycles addr -> data.
  always @(posedge clk) begin
    ram_addr_q   <= ram_addr_rd;
    ram_data_out <= mem[ram_addr_q];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observes the DUT mid-cycle and scores it against the reference word list.
  task automatic sample();
    if (prev_busy && ram_addr_rd !== prev_addr) issues++;
    prev_busy = busy;
    prev_addr = ram_addr_rd;
    if (done === 1'b1) begin
      done_flag    = 1'b1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (m_valid === 1'b1) begin
      if (!seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (exp_q.size() == 0) check("valid_without_data", 32'(m_valid), 0);
      else begin
        check("data", 32'(m_data), 32'(exp_q[0]));
        check("last", 32'(m_last), 32'(exp_q.size() == 1));
        if (m_ready) begin
          void'(exp_q.pop_front());
          pops++;
          last_hs_cyc = cyc;
        end
      end
    end
    if (busy === 1'b1) check("credit_le_4", 32'(((issues - iss0) - (pops - pops0)) <= 4), 1);
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic run_job(input int base, input int len, input bit stall, input bit spur, input bit chk_lat);
    for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % D]);
    iss0 = issues; pops0 = pops;
    seen_valid = 1'b0; done_flag = 1'b0;
    start_cyc = cyc;
    base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
    cycle();
    start = 1'b0; base_addr = AW'($urandom); length = (AW+1)'($urandom_range(0, D));
    for (int t = 0; t < 400 && !done_flag; t++) begin
      if (stall && t == 6)  rdy_mode = 2;
      if (stall && t == 16) rdy_mode = 1;
      if (spur && t == 3) begin
        start = 1'b1; base_addr = AW'(base + 7); length = (AW+1)'(2);
      end
      if (spur && t == 4) start = 1'b0;
      cycle();
    end
    check("done_seen", 32'(done_flag), 1);
    check("all_words_streamed", 32'(exp_q.size()), 0);
    check("reads_issued", 32'(issues - iss0), 32'(len));
    if (len > 0) begin
      check("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
      check("busy_in_done", 32'(busy_at_done), 1);
    end else begin
      check("len0_done_within_2", 32'((done_cyc - start_cyc) <= 2), 1);
      check("len0_no_valid", 32'(seen_valid), 0);
    end
    if (chk_lat) check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 4);
    exp_q.delete();
    rdy_mode = 0;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'(i);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    cycle(); cycle();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_addr", 32'(ram_addr_rd), 0);
    rst = 1'b0;
    cycle();

    run_job(5, 4, 0, 0, 1);    // 5,6,7,8 back to back
    run_job(14, 4, 0, 0, 1);   // 14,15,0,1 across the wrap
    run_job(7, 0, 0, 0, 0);    // empty job
    rdy_mode = 0;
    run_job(2, 12, 1, 0, 0);   // long stall then random ready
    run_job(3, 16, 0, 0, 1);   // every word once
    rdy_mode = 1;
    run_job(10, 9, 0, 1, 0);   // start while busy is ignored

    // Reset mid-job with the FIFO holding data, then a fresh job.
    rdy_mode = 2;
    iss0 = issues; pops0 = pops; seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) exp_q.push_back(mem[(2 + k) % D]);
    base_addr = AW'(2); length = (AW+1)'(12); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 7; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_valid", 32'(m_valid), 0);
    check("midrst_last", 32'(m_last), 0);
    check("midrst_addr", 32'(ram_addr_rd), 0);
    exp_q.delete();
    rdy_mode = 0;
    for (int i = 0; i < D; i++) mem[i] = W'(8'hA0 + i);
    cycle();
    run_job(9, 5, 0, 0, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < D; i++) mem[i] = W'($urandom);
      rdy_mode = 1;
      run_job($urandom_range(0, D - 1), $urandom_range(1, D), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
